// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decode + sign-extend to XLEN behind a valid/ready
// stage built from an output register and one skid entry. Define IMM_GEN_CSR_EN for CSR zimm.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       imm_fmt,
  output logic             imm_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int DW = TAG_W + 4 + XLEN;
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_CSR_EN
  localparam logic [2:0] FMT_Z    = 3'd6;
`endif

  // Returns {illegal, fmt, imm}; the immediate is built at 64 bits and truncated to XLEN.
  function automatic logic [XLEN+3:0] decode(input logic [31:0] ins);
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic        sx;
    sx  = ins[31];
    imm = 64'd0;
    fmt = FMT_NONE;
    ill = 1'b0;
    case (ins[6:0])
      7'b0000011, 7'b1100111: begin
        fmt = FMT_I;
        imm = {{52{sx}}, ins[31:20]};
      end
      7'b0010011: begin
        fmt = FMT_I;
        if (ins[13:12] == 2'b01) begin
          if (XLEN == 64) imm = {58'd0, ins[25:20]};
          else            imm = {59'd0, ins[24:20]};
        end else begin
          imm = {{52{sx}}, ins[31:20]};
        end
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          fmt = FMT_I;
          if (ins[13:12] == 2'b01) imm = {59'd0, ins[24:20]};
          else                     imm = {{52{sx}}, ins[31:20]};
        end else begin
          ill = 1'b1;
        end
      end
      7'b0100011: begin
        fmt = FMT_S;
        imm = {{52{sx}}, ins[31:25], ins[11:7]};
      end
      7'b1100011: begin
        fmt = FMT_B;
        imm = {{52{sx}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b1101111: begin
        fmt = FMT_J;
        imm = {{44{sx}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt = FMT_U;
        imm = {{32{sx}}, ins[31:12], 12'd0};
      end
      7'b0110011, 7'b0001111: begin
        fmt = FMT_NONE;
      end
      7'b0111011: begin
        if (XLEN == 64) ill = 1'b0;
        else            ill = 1'b1;
      end
      7'b1110011: begin
`ifdef IMM_GEN_CSR_EN
        if (ins[14]) begin
          fmt = FMT_Z;
          imm = {59'd0, ins[19:15]};
        end else begin
          fmt = FMT_NONE;
        end
`else
        fmt = FMT_NONE;
        imm = 64'd0;
`endif
      end
      default: ill = 1'b1;
    endcase
    return {ill, fmt, imm[XLEN-1:0]};
  endfunction

  logic          out_valid_r, skid_valid_r, in_ready_r;
  logic [DW-1:0] out_data_r, skid_data_r;
  logic          out_valid_s, skid_valid_s, accept_s, xfer_s;
  logic [DW-1:0] out_data_s, skid_data_s, new_data_s;

  assign accept_s   = in_valid & in_ready_r;
  assign xfer_s     = out_valid_r & out_ready;
  assign new_data_s = {in_tag, decode(in_instr)};

  // Next-state of output register and skid entry; the skid only refills the output when it frees up.
  always_comb begin
    out_valid_s  = out_valid_r;
    out_data_s   = out_data_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    if (flush) begin
      out_valid_s  = 1'b0;
      skid_valid_s = 1'b0;
    end else if (!out_valid_r || xfer_s) begin
      if (skid_valid_r) begin
        out_valid_s = 1'b1;
        out_data_s  = skid_data_r;
        if (accept_s) begin
          skid_data_s = new_data_s;
        end else begin
          skid_valid_s = 1'b0;
        end
      end else if (accept_s) begin
        out_valid_s = 1'b1;
        out_data_s  = new_data_s;
      end else begin
        out_valid_s = 1'b0;
      end
    end else if (accept_s) begin
      skid_valid_s = 1'b1;
      skid_data_s  = new_data_s;
    end else begin
      skid_valid_s = skid_valid_r;
    end
  end

  // Pipeline state; in_ready stays low during reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= '0;
      in_ready_r   <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_s;
      out_data_r   <= out_data_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      in_ready_r   <= !skid_valid_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign {out_tag, imm_illegal, imm_fmt, imm_out} = out_data_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are checked
// against a queue-based reference model. Honors IMM_GEN_CSR_EN when defined.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [3:0]  in_tag;

  logic        ir32, ov32, il32;
  logic [31:0] im32;
  logic [2:0]  fm32;
  logic [3:0]  tg32;
  logic        ir64, ov64, il64;
  logic [63:0] im64;
  logic [2:0]  fm64;
  logic [3:0]  tg64;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef IMM_GEN_CSR_EN
  localparam bit CSR_ON = 1'b1;
`else
  localparam bit CSR_ON = 1'b0;
`endif

  typedef struct {
    logic [63:0] i32; logic [63:0] i64;
    logic [2:0]  f32; logic [2:0]  f64;
    logic        l32; logic        l64;
    logic [3:0]  tag;
  } exp_t;
  exp_t q[$];

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
    .imm_out(im32), .imm_fmt(fm32), .imm_illegal(il32), .out_tag(tg32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
    .imm_out(im64), .imm_fmt(fm64), .imm_illegal(il64), .out_tag(tg64));

  always #5 clk = ~clk;

  // Reference decode: field rules evaluated as signed integer arithmetic.
  function automatic void ref_dec(input logic [31:0] ins, input int xlen,
                                  output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
    longint v;
    int     f;
    v = 0; f = 0; ill = 1'b0;
    case (ins[6:0])
      7'h03, 7'h67: begin f = 1; v = longint'($signed(ins[31:20])); end
      7'h13: begin
        f = 1;
        if (ins[13:12] == 2'b01) v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
        else v = longint'($signed(ins[31:20]));
      end
      7'h1B: begin
        if (xlen == 32) ill = 1'b1;
        else begin
          f = 1;
          if (ins[13:12] == 2'b01) v = longint'(ins[24:20]);
          else v = longint'($signed(ins[31:20]));
        end
      end
      7'h23: begin f = 2; v = longint'($signed({ins[31:25], ins[11:7]})); end
      7'h63: begin f = 3; v = 2 * longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})); end
      7'h6F: begin f = 5; v = 2 * longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})); end
      7'h37, 7'h17: begin f = 4; v = longint'($signed(ins[31:12])) * 4096; end
      7'h33, 7'h0F: f = 0;
      7'h3B: ill = (xlen == 32);
      7'h73: if (CSR_ON && ins[14]) begin f = 6; v = longint'(ins[19:15]); end
      default: ill = 1'b1;
    endcase
    imm = (xlen == 32) ? {32'd0, 32'(v)} : 64'(v);
    fmt = 3'(f);
  endfunction

  function automatic exp_t make_exp(input logic [31:0] ins, input logic [3:0] tag);
    exp_t e;
    ref_dec(ins, 32, e.i32, e.f32, e.l32);
    ref_dec(ins, 64, e.i64, e.f64, e.l64);
    e.tag = tag;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [14] = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h6F,
                              7'h37, 7'h17, 7'h33, 7'h3B, 7'h0F, 7'h73, 7'h7F};
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 13)];
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_tag = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ov32, im32, fm32, il32, tg32, ov64, im64, fm64, il64, tg64} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ov32=%0b imm32=%h ov64=%0b imm64=%h, expected all zero",
               ov32, im32, ov64, im64);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({ir32, ir64, ov32, ov64} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%0b%0b out_valid=%0b%0b, expected 11 00",
               ir32, ir64, ov32, ov64);
    end
  endtask

  task automatic test_decode_vectors();
    logic [31:0] ins [8] = '{32'hFFF00093, 32'h03F09093, 32'h800000B7, 32'hFFDFF06F,
                             32'h0000007F, 32'h34015073, 32'h0000003B, 32'h01F0909B};
    logic [31:0] e32 [8] = '{32'hFFFFFFFF, 32'h0000001F, 32'h80000000, 32'hFFFFFFFC,
                             32'h0, (CSR_ON ? 32'h2 : 32'h0), 32'h0, 32'h0};
    logic [63:0] e64 [8] = '{64'hFFFFFFFFFFFFFFFF, 64'h3F, 64'hFFFFFFFF80000000,
                             64'hFFFFFFFFFFFFFFFC, 64'h0, (CSR_ON ? 64'h2 : 64'h0), 64'h0, 64'h1F};
    logic [2:0]  f32 [8] = '{3'd1, 3'd1, 3'd4, 3'd5, 3'd0, (CSR_ON ? 3'd6 : 3'd0), 3'd0, 3'd0};
    logic [2:0]  f64 [8] = '{3'd1, 3'd1, 3'd4, 3'd5, 3'd0, (CSR_ON ? 3'd6 : 3'd0), 3'd0, 3'd1};
    logic        l32 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        l64 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      in_instr = ins[i]; in_tag = 4'(i + 5); in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({ov32, tg32, il32, fm32, im32} !== {1'b1, 4'(i + 5), l32[i], f32[i], e32[i]}) begin
        n_fail++;
        $display("FAIL decode32[%0d] instr=%h: got v=%0b tag=%0d ill=%0b fmt=%0d imm=%h, expected v=1 tag=%0d ill=%0b fmt=%0d imm=%h",
                 i, ins[i], ov32, tg32, il32, fm32, im32, i + 5, l32[i], f32[i], e32[i]);
      end
      n_checks++;
      if ({ov64, tg64, il64, fm64, im64} !== {1'b1, 4'(i + 5), l64[i], f64[i], e64[i]}) begin
        n_fail++;
        $display("FAIL decode64[%0d] instr=%h: got v=%0b tag=%0d ill=%0b fmt=%0d imm=%h, expected v=1 tag=%0d ill=%0b fmt=%0d imm=%h",
                 i, ins[i], ov64, tg64, il64, fm64, im64, i + 5, l64[i], f64[i], e64[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int nacc = 0;
    int tag  = 1;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
    for (int c = 0; c < 4; c++) begin
      in_tag = 4'(tag);
      @(negedge clk);
      if (ir32) begin nacc++; tag++; end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (nacc != 2 || ir32 !== 1'b0 || ir64 !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_fill: got accepted=%0d in_ready=%0b%0b, expected accepted=2 in_ready=00",
               nacc, ir32, ir64);
    end
    @(posedge clk); #1;
    in_tag = 4'(tag); out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (ov32 !== 1'b1 || tg32 !== 4'(k) || ov64 !== 1'b1 || tg64 !== 4'(k)) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: got valid=%0b tag=%0d (64: %0b %0d), expected valid=1 tag=%0d",
                 k, ov32, tg32, ov64, tg64, k);
      end
      if (in_valid && ir32) tag++;
      @(posedge clk); #1;
      if (tag > 3) in_valid = 1'b0;
      in_tag = 4'(tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500113;
    for (int c = 0; c < 3; c++) begin
      in_tag = 4'(c + 8);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ov32, ov64, ir32, ir64} !== 4'b0011) begin
      n_fail++;
      $display("FAIL flush: got out_valid=%0b%0b in_ready=%0b%0b, expected 00 11", ov32, ov64, ir32, ir64);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({ov32, ov64} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_no_residue: got out_valid=%0b%0b, expected 00", ov32, ov64);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 4'hA;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ov32, im32, fm32, il32, tg32, ov64, im64, fm64, il64, tg64} !== '0) begin
      n_fail++;
      $display("FAIL reset_midstream: got ov=%0b%0b imm32=%h tag32=%0d, expected all zero",
               ov32, ov64, im32, tg32);
    end
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({ir32, ir64, ov32, ov64} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_midstream_release: got in_ready=%0b%0b out_valid=%0b%0b, expected 11 00",
               ir32, ir64, ov32, ov64);
    end
  endtask

  task automatic test_random();
    logic acc, xf;
    flush = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    q.delete();
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      in_instr  = rand_instr();
      in_tag    = 4'($urandom_range(0, 15));
      @(negedge clk);
      n_checks++;
      if (ir32 !== (q.size() < 2) || ir64 !== (q.size() < 2) ||
          ov32 !== (q.size() > 0) || ov64 !== (q.size() > 0)) begin
        n_fail++;
        $display("FAIL rand_handshake cyc=%0d: got in_ready=%0b%0b out_valid=%0b%0b, expected held=%0d",
                 c, ir32, ir64, ov32, ov64, q.size());
      end else if (q.size() > 0) begin
        n_checks++;
        if ({tg32, il32, fm32, im32} !== {q[0].tag, q[0].l32, q[0].f32, q[0].i32[31:0]} ||
            {tg64, il64, fm64, im64} !== {q[0].tag, q[0].l64, q[0].f64, q[0].i64}) begin
          n_fail++;
          $display("FAIL rand_data cyc=%0d: got tag=%0d ill=%0b fmt=%0d imm32=%h / ill=%0b fmt=%0d imm64=%h, expected tag=%0d ill=%0b fmt=%0d imm32=%h / ill=%0b fmt=%0d imm64=%h",
                   c, tg32, il32, fm32, im32, il64, fm64, im64,
                   q[0].tag, q[0].l32, q[0].f32, q[0].i32[31:0], q[0].l64, q[0].f64, q[0].i64);
        end
      end
      acc = in_valid && (q.size() < 2);
      xf  = out_ready && (q.size() > 0);
      @(posedge clk);
      if (flush) q.delete();
      else begin
        if (xf)  void'(q.pop_front());
        if (acc) q.push_back(make_exp(in_instr, in_tag));
      end
      #1;
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode_vectors();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
